// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory / writeback pipeline stage:
// FSM encoding, funct3 and writeback-select codes, control layout and
// small access-size helpers.
package mem_wb_stage_pkg;

    // Memory handshake FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access width, taken from funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Writeback select codes (interpreted by the writeback stage)
    localparam logic [1:0] WB_FU   = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    // Control word arriving from execute
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [1:0] sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } ctrl_t;

    // Control word handed on to writeback
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [1:0] sel;
    } wb_ctrl_t;

    // True when the address low bits do not suit the access width
    function automatic logic addr_misaligned(input logic [1:0] width, input logic [1:0] lsb);
        logic result;
        case (width)
            SZ_BYTE: result = 1'b0;
            SZ_HALF: result = lsb[0];
            default: result = |lsb;
        endcase
        return result;
    endfunction

    // Byte-lane enables for an access of the given width at the given offset
    function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] lsb);
        logic [3:0] result;
        case (width)
            SZ_BYTE: result = 4'b0001 << lsb;
            SZ_HALF: result = 4'b0011 << lsb;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_wb_stage_if #(
    parameter int size = 32
);
    logic            mem_req_o;
    logic            mem_we_o;
    logic [size-1:0] mem_addr_o;
    logic [size-1:0] mem_wdata_o;
    logic [3:0]      mem_be_o;
    logic            mem_ack_i;
    logic [size-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load alignment: picks the addressed lane out of the read word and
// sign- or zero-extends it according to funct3.
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [size-1:0] value
);

    logic [size-1:0] lane;

    // Shift the addressed byte lane down to bit 0, then extend
    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   value = {{(size-8){lane[7]}}, lane[7:0]};
            F3_LBU:  value = {{(size-8){1'b0}}, lane[7:0]};
            F3_LH:   value = {{(size-16){lane[15]}}, lane[15:0]};
            F3_LHU:  value = {{(size-16){1'b0}}, lane[15:0]};
            default: value = lane;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / writeback pipeline stage. Non-memory instructions pass through
// in one cycle; loads and stores hold the upstream stage until the memory
// acknowledges or a wait-cycle budget expires. Misaligned accesses and
// timeouts are reported as single-cycle pulses and retire as bubbles.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int size    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [size-1:0]  FU_i,
    input  logic [size-1:0]  store_data_i,
    input  logic [size-1:0]  PCplus_i,
    input  logic [12:0]      ctrl_i,
    output logic             stall_o,
    mem_wb_stage_if.master   mem,
    output logic [size-1:0]  FU_o,
    output logic [size-1:0]  MEM_result_o,
    output logic [size-1:0]  PCplus_o,
    output logic [7:0]       Control_Signal_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_t           ctrl;
    wb_ctrl_t        wb_ctrl;
    logic [1:0]      width;
    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            is_mem;
    logic            misaligned;
    logic            aligned;
    logic            timeout;
    logic            req;
    logic            ack_seen;
    logic            stall;
    logic            bubble;
    logic [size-1:0] load_value;

    assign ctrl    = ctrl_t'(ctrl_i);
    assign wb_ctrl = '{rd: ctrl.rd, we: ctrl.we, sel: ctrl.sel};
    assign width   = ctrl.funct3[1:0];

    // Classify the incoming instruction
    always_comb begin
        is_mem     = valid_i & (ctrl.mem_read | ctrl.mem_write);
        misaligned = is_mem & addr_misaligned(width, FU_i[1:0]);
        aligned    = is_mem & ~misaligned;
    end

    // The last permitted wait cycle gives up instead of requesting again
    assign timeout  = (state_reg == ST_WAIT) && (count_reg == CW'(TIMEOUT - 1));
    assign req      = rst_n & aligned & ~timeout;
    assign ack_seen = req & mem.mem_ack_i;
    assign stall    = req & ~mem.mem_ack_i;
    assign bubble   = ~valid_i | misaligned | stall | timeout;

    assign stall_o    = stall;
    assign misalign_o = rst_n & misaligned;
    assign bus_err_o  = rst_n & timeout;

    // Bus outputs follow the held instruction, so they stay stable while waiting
    assign mem.mem_req_o  = req;
    assign mem.mem_we_o   = ctrl.mem_write;
    assign mem.mem_addr_o = {FU_i[size-1:2], 2'b00};
    assign mem.mem_be_o   = byte_enables(width, FU_i[1:0]);

    // Store data replicated across every byte lane that could be selected
    generate
        for (genvar gi = 0; gi < size / 8; gi++) begin : g_wdata_lane
            assign mem.mem_wdata_o[gi*8 +: 8] =
                (width == SZ_BYTE) ? store_data_i[7:0] :
                (width == SZ_HALF) ? store_data_i[(gi % 2)*8 +: 8] :
                                     store_data_i[gi*8 +: 8];
        end
    endgenerate

    load_extend #(.size(size)) u_load_extend (
        .rdata  (mem.mem_rdata_i),
        .offset (FU_i[1:0]),
        .funct3 (ctrl.funct3),
        .value  (load_value)
    );

    // Handshake state and wait-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state: wait while an access is outstanding, leave on ack or timeout
    always_comb begin
        state_next = state_reg;
        count_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (stall) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!aligned || ack_seen || timeout) state_next = ST_IDLE;
                else                                 count_next = count_reg + CW'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Writeback register: bubble unless the instruction retires this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FU_o             <= '0;
            MEM_result_o     <= '0;
            PCplus_o         <= '0;
            Control_Signal_o <= '0;
        end else if (bubble) begin
            FU_o             <= '0;
            MEM_result_o     <= '0;
            PCplus_o         <= '0;
            Control_Signal_o <= '0;
        end else begin
            FU_o             <= FU_i;
            MEM_result_o     <= (ctrl.mem_read && ack_seen) ? load_value : '0;
            PCplus_o         <= PCplus_i;
            Control_Signal_o <= wb_ctrl;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// instruction streams compared against an arithmetic reference model.
module tb_mem_wb_stage;

    localparam int SIZE = 32;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] FU_i = '0;
    logic [31:0] store_data_i = '0;
    logic [31:0] PCplus_i = '0;
    logic [12:0] ctrl_i = '0;
    logic        stall_o, misalign_o, bus_err_o;
    logic [31:0] FU_o, MEM_result_o, PCplus_o;
    logic [7:0]  Control_Signal_o;

    int checks = 0;
    int errors = 0;

    logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    mem_wb_stage_if #(.size(SIZE)) mem_bus();

    mem_wb_stage #(.size(SIZE), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .FU_i             (FU_i),
        .store_data_i     (store_data_i),
        .PCplus_i         (PCplus_i),
        .ctrl_i           (ctrl_i),
        .stall_o          (stall_o),
        .mem              (mem_bus),
        .FU_o             (FU_o),
        .MEM_result_o     (MEM_result_o),
        .PCplus_o         (PCplus_o),
        .Control_Signal_o (Control_Signal_o),
        .misalign_o       (misalign_o),
        .bus_err_o        (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall_cycles;
        int          req_cycles;
        int          err_count;
        int          err_cycle;
        int          bubble_bad;
        logic        mis_seen;
        logic        unstable;
        logic        hung;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic logic [12:0] mk_ctrl(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                                            input logic mr, input logic mw, input logic [2:0] f3);
        return {rd, we, sel, mr, mw, f3};
    endfunction

    function automatic int model_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % 32'(model_bytes(f3))) != 32'd0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << model_bytes(f3)) - 1) << (addr % 32'd4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (model_bytes(f3) == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (model_bytes(f3) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] shifted, b, h;
        shifted = word >> (32'd8 * (addr % 32'd4));
        b = shifted & 32'hFF;
        h = shifted & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input logic [2:0] f3, input logic aligned);
        int          bytes;
        int          off;
        logic [31:0] base;
        bytes = model_bytes(f3);
        base  = $urandom & 32'hFFFF_FFFC;
        if (aligned)          off = bytes * int'($urandom_range(0, 4 / bytes - 1));
        else if (bytes == 2)  off = 2 * int'($urandom_range(0, 1)) + 1;
        else                  off = int'($urandom_range(1, 3));
        return base + 32'(off);
    endfunction

    // ---------------- driver ----------------
    // Presents one instruction at edge+1 and holds it while stalled; ack is
    // raised in cycle ack_after (0 = same cycle, -1 = never).
    task automatic issue(input logic v, input logic [12:0] c, input logic [31:0] fu, input logic [31:0] sd,
                         input logic [31:0] pc, input int ack_after, input logic [31:0] rdata, output obs_t o);
        int   cyc;
        logic done;
        o.stall_cycles = 0; o.req_cycles = 0; o.err_count = 0; o.err_cycle = -1; o.bubble_bad = 0;
        o.mis_seen = 1'b0; o.unstable = 1'b0; o.hung = 1'b0; o.we = 1'b0;
        o.be = '0; o.addr = '0; o.wdata = '0;
        valid_i = v; ctrl_i = c; FU_i = fu; store_data_i = sd; PCplus_i = pc;
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            mem_bus.mem_ack_i   = (cyc == ack_after);
            mem_bus.mem_rdata_i = (cyc == ack_after) ? rdata : $urandom;
            #3;
            if (mem_bus.mem_req_o) begin
                if (o.req_cycles == 0) begin
                    o.we = mem_bus.mem_we_o; o.be = mem_bus.mem_be_o;
                    o.addr = mem_bus.mem_addr_o; o.wdata = mem_bus.mem_wdata_o;
                end else if (o.be !== mem_bus.mem_be_o || o.addr !== mem_bus.mem_addr_o ||
                             o.wdata !== mem_bus.mem_wdata_o || o.we !== mem_bus.mem_we_o) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles++;
            end
            if (misalign_o) o.mis_seen = 1'b1;
            if (bus_err_o) begin o.err_count++; o.err_cycle = cyc; end
            if (stall_o) o.stall_cycles++;
            else         done = 1'b1;
            @(posedge clk); #1;
            if (!done && (Control_Signal_o !== 8'h0 || FU_o !== 32'h0 || MEM_result_o !== 32'h0 || PCplus_o !== 32'h0))
                o.bubble_bad++;
            cyc++;
            if (!done && cyc >= 40) begin o.hung = 1'b1; done = 1'b1; end
        end
        valid_i = 1'b0;
        mem_bus.mem_ack_i = 1'b0;
        $display("txn v=%0d ctrl=%h fu=%h stall=%0d req=%0d mis=%0d err=%0d wb_ctrl=%h fu_o=%h mem_o=%h",
                 v, c, fu, o.stall_cycles, o.req_cycles, o.mis_seen, o.err_count, Control_Signal_o, FU_o, MEM_result_o);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        valid_i = 1'b1; ctrl_i = mk_ctrl(5'd3, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2); FU_i = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_bus.mem_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        checks++; if (Control_Signal_o !== 8'h0) begin errors++; $display("FAIL reset_ctrl got %h want 00", Control_Signal_o); end
        checks++; if (FU_o !== 32'h0 || MEM_result_o !== 32'h0 || PCplus_o !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h want 0", FU_o, MEM_result_o, PCplus_o); end
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        obs_t        o;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] fu, pc;
        issue(1'b1, mk_ctrl(5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0), 32'h1234, 32'h0, 32'h88, 0, 32'hDEAD_BEEF, o);
        checks++; if (FU_o !== 32'h1234) begin errors++; $display("FAIL alu_fu got %h want 00001234", FU_o); end
        checks++; if (Control_Signal_o !== 8'h2C) begin errors++; $display("FAIL alu_ctrl got %h want 2c", Control_Signal_o); end
        checks++; if (o.stall_cycles !== 0 || o.req_cycles !== 0) begin
            errors++; $display("FAIL alu_stall got stall=%0d req=%0d want 0 0", o.stall_cycles, o.req_cycles); end
        for (int n = 0; n < 6; n++) begin
            rd = 5'($urandom); we = 1'($urandom); sel = 2'($urandom); fu = $urandom; pc = $urandom;
            issue(1'b1, mk_ctrl(rd, we, sel, 1'b0, 1'b0, 3'($urandom)), fu, $urandom, pc, int'($urandom_range(0, 1)), $urandom, o);
            checks++; if (FU_o !== fu || PCplus_o !== pc || Control_Signal_o !== {rd, we, sel} || MEM_result_o !== 32'h0) begin
                errors++; $display("FAIL alu_rand got %h %h %h %h want %h %h %h 0", FU_o, PCplus_o, Control_Signal_o, MEM_result_o, fu, pc, {rd, we, sel}); end
        end
    endtask

    task automatic test_load();
        obs_t        o;
        logic [2:0]  f3;
        logic [31:0] addr, word;
        int          w;
        issue(1'b1, mk_ctrl(5'd7, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0), 32'h103, 32'h0, 32'h500, 3, 32'h80FF_FF7F, o);
        checks++; if (o.stall_cycles !== 3) begin errors++; $display("FAIL lb_stall got %0d want 3", o.stall_cycles); end
        checks++; if (o.bubble_bad !== 0) begin errors++; $display("FAIL lb_bubbles got %0d nonzero want 0", o.bubble_bad); end
        checks++; if (MEM_result_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", MEM_result_o); end
        checks++; if (o.addr !== 32'h100 || o.we !== 1'b0 || o.unstable !== 1'b0) begin
            errors++; $display("FAIL lb_bus got addr=%h we=%b unstable=%b want 100 0 0", o.addr, o.we, o.unstable); end
        for (int n = 0; n < 8; n++) begin
            f3 = load_f3[$urandom_range(0, 4)];
            addr = rand_addr(f3, 1'b1);
            word = $urandom;
            w = int'($urandom_range(0, 6));
            issue(1'b1, mk_ctrl(5'($urandom), 1'b1, 2'b01, 1'b1, 1'b0, f3), addr, 32'h0, 32'h44, w, word, o);
            checks++; if (MEM_result_o !== model_load(f3, addr, word) || o.stall_cycles !== w) begin
                errors++; $display("FAIL load_rand f3=%0d addr=%h got %h stall=%0d want %h stall=%0d",
                                   f3, addr, MEM_result_o, o.stall_cycles, model_load(f3, addr, word), w); end
        end
    endtask

    task automatic test_store();
        obs_t        o;
        logic [2:0]  f3;
        logic [31:0] addr, sd;
        issue(1'b1, mk_ctrl(5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'd1), 32'h202, 32'hABCD, 32'h10, 0, 32'h0, o);
        checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", o.be); end
        checks++; if (o.wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", o.wdata); end
        checks++; if (o.stall_cycles !== 0 || o.we !== 1'b1 || o.req_cycles !== 1) begin
            errors++; $display("FAIL sh_hs got stall=%0d we=%b req=%0d want 0 1 1", o.stall_cycles, o.we, o.req_cycles); end
        for (int n = 0; n < 6; n++) begin
            f3 = 3'($urandom_range(0, 2));
            addr = rand_addr(f3, 1'b1);
            sd = $urandom;
            issue(1'b1, mk_ctrl(5'd0, 1'b0, 2'b00, 1'b0, 1'b1, f3), addr, sd, 32'h20, int'($urandom_range(0, 4)), 32'h0, o);
            checks++; if (o.be !== model_be(f3, addr) || o.wdata !== model_wdata(f3, sd) || o.addr !== (addr & 32'hFFFF_FFFC)) begin
                errors++; $display("FAIL store_rand f3=%0d addr=%h got be=%b wd=%h a=%h want be=%b wd=%h",
                                   f3, addr, o.be, o.wdata, o.addr, model_be(f3, addr), model_wdata(f3, sd)); end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        issue(1'b1, mk_ctrl(5'd9, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2), 32'h101, 32'h0, 32'h30, 0, 32'h1111_2222, o);
        checks++; if (o.mis_seen !== 1'b1) begin errors++; $display("FAIL lw_mis_pulse got %b want 1", o.mis_seen); end
        checks++; if (o.req_cycles !== 0 || o.stall_cycles !== 0) begin
            errors++; $display("FAIL lw_mis_req got req=%0d stall=%0d want 0 0", o.req_cycles, o.stall_cycles); end
        checks++; if (Control_Signal_o !== 8'h0 || FU_o !== 32'h0 || MEM_result_o !== 32'h0) begin
            errors++; $display("FAIL lw_mis_bubble got %h %h %h want 0", Control_Signal_o, FU_o, MEM_result_o); end
    endtask

    task automatic test_timeout();
        obs_t o;
        issue(1'b1, mk_ctrl(5'd4, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2), 32'h400, 32'h0, 32'h60, -1, 32'h0, o);
        checks++; if (o.err_cycle !== TMO || o.err_count !== 1) begin
            errors++; $display("FAIL timeout_err got cycle=%0d count=%0d want %0d 1", o.err_cycle, o.err_count, TMO); end
        checks++; if (o.stall_cycles !== TMO || o.hung !== 1'b0) begin
            errors++; $display("FAIL timeout_stall got %0d hung=%b want %0d 0", o.stall_cycles, o.hung, TMO); end
        checks++; if (Control_Signal_o !== 8'h0 || o.bubble_bad !== 0) begin
            errors++; $display("FAIL timeout_bubble got %h bad=%0d want 0 0", Control_Signal_o, o.bubble_bad); end
        issue(1'b1, mk_ctrl(5'd4, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2), 32'h400, 32'h0, 32'h60, 1, 32'h5A5A_1234, o);
        checks++; if (MEM_result_o !== 32'h5A5A_1234 || o.stall_cycles !== 1) begin
            errors++; $display("FAIL after_timeout got %h stall=%0d want 5a5a1234 1", MEM_result_o, o.stall_cycles); end
    endtask

    task automatic test_bubble();
        obs_t o;
        issue(1'b0, mk_ctrl(5'd6, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2), 32'h800, 32'h0, 32'h70, 0, 32'h1, o);
        checks++; if (o.req_cycles !== 0 || o.stall_cycles !== 0 || Control_Signal_o !== 8'h0 || FU_o !== 32'h0) begin
            errors++; $display("FAIL idle_bubble got req=%0d stall=%0d ctrl=%h fu=%h want 0", o.req_cycles, o.stall_cycles, Control_Signal_o, FU_o); end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        valid_i = 1'b1; ctrl_i = mk_ctrl(5'd2, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2); FU_i = 32'h900; PCplus_i = 32'h4;
        mem_bus.mem_ack_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (mem_bus.mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
            errors++; $display("FAIL wait_active got req=%b stall=%b want 1 1", mem_bus.mem_req_o, stall_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req_o !== 1'b0 || stall_o !== 1'b0 || bus_err_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++; $display("FAIL rst_wait_comb got req=%b stall=%b err=%b mis=%b want 0", mem_bus.mem_req_o, stall_o, bus_err_o, misalign_o); end
        checks++; if (Control_Signal_o !== 8'h0 || FU_o !== 32'h0 || MEM_result_o !== 32'h0 || PCplus_o !== 32'h0) begin
            errors++; $display("FAIL rst_wait_regs got %h %h %h %h want 0", Control_Signal_o, FU_o, MEM_result_o, PCplus_o); end
        valid_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, mk_ctrl(5'd2, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2), 32'h900, 32'h0, 32'h4, 0, 32'hCAFE_F00D, o);
        checks++; if (MEM_result_o !== 32'hCAFE_F00D || o.stall_cycles !== 0) begin
            errors++; $display("FAIL post_reset_load got %h stall=%0d want cafef00d 0", MEM_result_o, o.stall_cycles); end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        int          kind, w, exp_stall;
        logic        v, mr, mw, we, is_mem, mis, bub;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] addr, sd, pc, word, exp_mem;
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 4));
            v  = (kind != 4);
            mr = (kind == 1) || (kind == 4) || (kind == 3 && $urandom_range(0, 1) == 1);
            mw = (kind == 2) || (kind == 3 && !mr);
            case (kind)
                1, 4:    f3 = load_f3[$urandom_range(0, 4)];
                2:       f3 = 3'($urandom_range(0, 2));
                3:       f3 = 3'($urandom_range(1, 2));
                default: f3 = 3'($urandom);
            endcase
            addr = (kind == 0) ? $urandom : rand_addr(f3, kind != 3);
            rd = 5'($urandom); we = 1'($urandom); sel = 2'($urandom);
            sd = $urandom; pc = $urandom; word = $urandom;
            w = int'($urandom_range(0, 6));
            issue(v, mk_ctrl(rd, we, sel, mr, mw, f3), addr, sd, pc, w, word, o);
            is_mem    = v && (mr || mw);
            mis       = is_mem && model_mis(f3, addr);
            bub       = !v || mis;
            exp_stall = (is_mem && !mis) ? w : 0;
            exp_mem   = (!bub && mr) ? model_load(f3, addr, word) : 32'h0;
            checks++; if (FU_o !== (bub ? 32'h0 : addr) || PCplus_o !== (bub ? 32'h0 : pc) ||
                          Control_Signal_o !== (bub ? 8'h0 : {rd, we, sel}) || MEM_result_o !== exp_mem) begin
                errors++; $display("FAIL b2b_regs kind=%0d got %h %h %h %h want fu=%h pc=%h ctrl=%h mem=%h bubble=%b",
                                   kind, FU_o, PCplus_o, Control_Signal_o, MEM_result_o, addr, pc, {rd, we, sel}, exp_mem, bub); end
            checks++; if (o.stall_cycles !== exp_stall || o.mis_seen !== mis || o.req_cycles !== ((is_mem && !mis) ? w + 1 : 0)) begin
                errors++; $display("FAIL b2b_hs kind=%0d got stall=%0d mis=%b req=%0d want %0d %b", kind, o.stall_cycles, o.mis_seen, o.req_cycles, exp_stall, mis); end
            if (is_mem && !mis) begin
                checks++; if (o.be !== model_be(f3, addr) || o.we !== mw || o.unstable !== 1'b0 ||
                              (mw && o.wdata !== model_wdata(f3, sd))) begin
                    errors++; $display("FAIL b2b_bus got be=%b we=%b wd=%h unstable=%b want be=%b we=%b wd=%h",
                                       o.be, o.we, o.wdata, o.unstable, model_be(f3, addr), mw, model_wdata(f3, sd)); end
            end
        end
    endtask

    initial begin
        mem_bus.mem_ack_i   = 1'b0;
        mem_bus.mem_rdata_i = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_bubble();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter size, default 32: datapath width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum wait cycles for a memory acknowledge before the access is aborted.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1: an instruction from the execute stage is present.
REQ-006 SHALL have port FU_i, input, size: ALU result, which is also the memory address.
REQ-007 SHALL have port store_data_i, input, size: rs2 value for stores.
REQ-008 SHALL have port PCplus_i, input, size: PC+4 of the instruction.
REQ-009 SHALL have port ctrl_i, input, 13, with fields:
- [12:8] rd;
- [7] reg write enable;
- [6:5] writeback select (00 FU, 01 MEM, 10 PC+, 11 zero);
- [4] mem_read;
- [3] mem_write;
- [2:0] funct3.
REQ-010 SHALL have port stall_o, input-side output, 1: the upstream stage must hold all inputs stable.
REQ-011 SHALL have port mem_req_o, output, 1: data memory request.
REQ-012 SHALL have port mem_we_o, output, 1: request is a write.
REQ-013 SHALL have port mem_addr_o, output, size: word-aligned address (FU_i with [1:0] forced to 0).
REQ-014 SHALL have port mem_wdata_o, output, size: lane-replicated store data.
REQ-015 SHALL have port mem_be_o, output, 4: byte enables.
REQ-016 SHALL have port mem_ack_i, input, 1: request completed; mem_rdata_i is valid in the same cycle.
REQ-017 SHALL have port mem_rdata_i, input, size: read word.
REQ-018 SHALL have output ports FU_o, MEM_result_o, PCplus_o, each size: registered values delivered to writeback.
REQ-019 SHALL have port Control_Signal_o, output, 8, encoded as {rd, we, sel}: registered control delivered to writeback.
REQ-020 SHALL have port misalign_o, output, 1: one-cycle pulse reporting a misaligned access.
REQ-021 SHALL have port bus_err_o, output, 1: one-cycle pulse reporting a memory timeout.

Function
REQ-022 SHALL treat an instruction as a memory access when valid_i=1 and ctrl_i[4] or ctrl_i[3] is set.
REQ-023 SHALL perform no memory request for non-memory instructions and SHALL register FU_i, PCplus_i and control at the next edge (1-cycle latency, no stall).
REQ-024 SHALL implement a two-state FSM, IDLE and WAIT:
- IDLE → WAIT when an aligned access is present and mem_ack_i=0;
- WAIT → IDLE on mem_ack_i or on timeout.
REQ-025 SHALL assert mem_req_o combinationally in IDLE for an aligned access and hold it high, with address, data and byte enables stable, in WAIT until ack.
REQ-026 SHALL accept a zero-wait ack: ack in the same IDLE cycle completes the access without entering WAIT.
REQ-027 SHALL set stall_o = memory access present and not (ack or timeout) in the current cycle.
REQ-028 SHALL load a bubble (Control_Signal_o[2]=0, other fields 0) into the output register on every stalled cycle.
REQ-029 SHALL align and extend loads on the ack cycle:
- select the lane by FU_i[1:0];
- funct3 000 sign-extends a byte (LB), 100 zero-extends a byte (LBU);
- 001 sign-extends a halfword (LH), 101 zero-extends a halfword (LHU);
- 010 passes the full word (LW).
REQ-030 SHALL generate stores as follows:
- SB: be=0001<<addr[1:0], byte replicated x4;
- SH: be=0011<<addr[1:0], halfword replicated x2;
- SW: be=1111.
REQ-031 SHALL detect misalignment (halfword with addr[0]=1, word with addr[1:0]≠0):
- issue no request and no stall;
- pulse misalign_o;
- register a bubble.
REQ-032 SHALL count WAIT cycles; at count TIMEOUT-1 without ack it SHALL:
- drop mem_req_o;
- pulse bus_err_o;
- release the stall;
- register a bubble;
- return to IDLE.
REQ-033 SHALL ignore mem_ack_i while mem_req_o=0.
REQ-034 SHALL register a valid_i=0 cycle as a bubble.

Reset
REQ-035 SHALL, while rst_n=0:
- force the FSM to IDLE and the counter to 0;
- drive all output registers to 0;
- hold mem_req_o, stall_o, misalign_o and bus_err_o at 0, including when reset is asserted mid-WAIT.
REQ-036 SHALL start accepting instructions on the first edge after rst_n deasserts.

Structure
REQ-037 SHALL place the FSM state encoding, funct3 codes and writeback-select codes in the shared core package.
REQ-038 SHALL implement load alignment and extension in one combinational sub-module named load_extend.

Verification
REQ-039 SHALL cover an ALU op: FU_i=0x1234, sel=00, we=1, rd=5 → next cycle FU_o=0x1234, Control_Signal_o=0x2C, stall_o=0 throughout.
REQ-040 SHALL cover LB: addr 0x103, rdata 0x80FF_FF7F, ack after 3 cycles → stall_o high for 3 cycles, 3 bubbles, then MEM_result_o=0xFFFF_FF80.
REQ-041 SHALL cover SH: addr 0x202, data 0xABCD, zero-wait ack → be=1100, wdata=0xABCD_ABCD, no stall.
REQ-042 SHALL cover LW at addr 0x101 → misalign_o pulse, mem_req_o=0, bubble output.
REQ-043 SHALL cover no ack with TIMEOUT=16 → bus_err_o pulses on the 16th WAIT cycle and stall_o releases.
REQ-044 SHALL cover rst_n low during WAIT → mem_req_o=0 immediately and all outputs 0.
